pe_array_ctrl: RTL

PE_ARRAY_CTRL -- requirements
Module: pe_array_ctrl

---
 rtl/pe_array_pkg.sv | 14 +
 rtl/pe_valid_delay.sv | 20 ++
 rtl/pe_array_ctrl.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/pe_array_pkg.sv
// Shared types and sizing for the PE-array job controller.
package pe_array_pkg;
  localparam int WMEM_ADDR_BITWIDTH_DEF = 8;
  localparam int NUM_ROWS_DEF           = 4;
  localparam int NUM_COLS_DEF           = 4;
  localparam int CNT_BITWIDTH_DEF       = 16;

  typedef enum logic [2:0] {IDLE, LOAD, COMPUTE, DRAIN, DONE} state_e;

  // One scratchpad read, one forwarding hop per row, one sum register per column.
  function automatic int drain_lat(input int rows, input int cols);
    return rows + cols + 1;
  endfunction
endpackage

// File: rtl/pe_valid_delay.sv
// Fixed-depth valid shift register with synchronous flush.
module pe_valid_delay #(
  parameter int DEPTH = 9
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_vld,
  output logic o_vld
);
  logic [DEPTH-1:0] r_vld_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)      r_vld_pipe <= '0;
    else if (i_clr) r_vld_pipe <= '0;
    else            r_vld_pipe <= (r_vld_pipe << 1) | DEPTH'(i_vld);
  end

  assign o_vld = r_vld_pipe[DEPTH-1];
endmodule

// File: rtl/pe_array_ctrl.sv
// Job sequencer for a weight-stationary PE array: weight load, activation
// issue with wrapping scratchpad reads, and a fixed drain before done.
module pe_array_ctrl
  import pe_array_pkg::*;
#(
  parameter int WMEM_ADDR_BITWIDTH = WMEM_ADDR_BITWIDTH_DEF,
  parameter int NUM_ROWS           = NUM_ROWS_DEF,
  parameter int NUM_COLS           = NUM_COLS_DEF,
  parameter int CNT_BITWIDTH       = CNT_BITWIDTH_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic                          abort,
  input  logic [WMEM_ADDR_BITWIDTH:0]   cfg_wgt_depth,
  input  logic [CNT_BITWIDTH-1:0]       cfg_num_act,
  input  logic                          wgt_valid,
  output logic                          wgt_ready,
  input  logic                          act_valid,
  output logic                          act_ready,
  output logic [NUM_ROWS-1:0]           write_req_w_mem,
  output logic [WMEM_ADDR_BITWIDTH-1:0] w_addr_w_mem,
  output logic                          read_req_w_mem,
  output logic [WMEM_ADDR_BITWIDTH-1:0] r_addr_w_mem,
  output logic                          sum_valid,
  output logic                          busy,
  output logic                          done
);
  localparam int AW        = WMEM_ADDR_BITWIDTH;
  localparam int DRAIN_LAT = drain_lat(NUM_ROWS, NUM_COLS);
  localparam int ROW_W     = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int DRN_W     = $clog2(DRAIN_LAT + 1);

  state_e                  r_state, w_next;
  logic [AW:0]             r_depth;
  logic [CNT_BITWIDTH-1:0] r_num_act, r_beat;
  logic [ROW_W-1:0]        r_row;
  logic [AW-1:0]           r_waddr, r_raddr;
  logic [DRN_W-1:0]        r_drn;
  logic w_abort, w_start, w_wbeat, w_abeat;
  logic w_last_row, w_last_waddr, w_last_raddr, w_last_beat, w_drn_end;

  // abort masks the handshakes in its own cycle so no beat is half-taken.
  assign w_abort      = abort && (r_state != IDLE);
  assign w_start      = start && (r_state == IDLE);
  assign w_wbeat      = (r_state == LOAD) && wgt_valid && !abort;
  assign w_abeat      = (r_state == COMPUTE) && act_valid && !abort;
  assign w_last_row   = (r_row == ROW_W'(NUM_ROWS - 1));
  assign w_last_waddr = ({1'b0, r_waddr} == (r_depth - (AW+1)'(1)));
  assign w_last_raddr = ({1'b0, r_raddr} == (r_depth - (AW+1)'(1)));
  assign w_last_beat  = (r_beat == (r_num_act - CNT_BITWIDTH'(1)));
  assign w_drn_end    = (r_drn == DRN_W'(DRAIN_LAT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next          = r_state;
    wgt_ready       = (r_state == LOAD) && !abort;
    act_ready       = (r_state == COMPUTE) && !abort;
    busy            = (r_state != IDLE);
    done            = (r_state == DONE) && !abort;
    read_req_w_mem  = w_abeat;
    write_req_w_mem = '0;
    if (w_wbeat) write_req_w_mem[r_row] = 1'b1;
    if (w_abort) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          if (cfg_wgt_depth != '0)    w_next = LOAD;
          else if (cfg_num_act != '0) w_next = COMPUTE;
          else                        w_next = DONE;
        end
        LOAD: if (w_wbeat && w_last_row && w_last_waddr) begin
          if (r_num_act == '0) w_next = DRAIN;
          else                 w_next = COMPUTE;
        end
        COMPUTE: if (w_abeat && w_last_beat) w_next = DRAIN;
        DRAIN:   if (w_drn_end) w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_depth   <= '0;
      r_num_act <= '0;
      r_row     <= '0;
      r_waddr   <= '0;
      r_raddr   <= '0;
      r_beat    <= '0;
      r_drn     <= '0;
    end else if (w_abort) begin
      r_row   <= '0;
      r_waddr <= '0;
      r_raddr <= '0;
      r_beat  <= '0;
      r_drn   <= '0;
    end else begin
      if (w_start) begin
        r_depth   <= cfg_wgt_depth;
        r_num_act <= cfg_num_act;
        r_row     <= '0;
        r_waddr   <= '0;
        r_raddr   <= '0;
        r_beat    <= '0;
        r_drn     <= '0;
      end
      // Rows are the inner loop so each address lands in every row before advancing.
      if (w_wbeat) begin
        if (w_last_row) begin
          r_row   <= '0;
          r_waddr <= w_last_waddr ? '0 : r_waddr + AW'(1);
        end else begin
          r_row <= r_row + ROW_W'(1);
        end
      end
      if (w_abeat) begin
        r_beat  <= w_last_beat ? '0 : r_beat + CNT_BITWIDTH'(1);
        r_raddr <= ((r_depth == '0) || w_last_raddr) ? '0 : r_raddr + AW'(1);
      end
      if (r_state == DRAIN) r_drn <= w_drn_end ? '0 : r_drn + DRN_W'(1);
    end
  end

  assign w_addr_w_mem = r_waddr;
  assign r_addr_w_mem = r_raddr;

  pe_valid_delay #(.DEPTH(DRAIN_LAT)) u_vld_dly (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_abort),
    .i_vld (w_abeat),
    .o_vld (sum_valid)
  );
endmodule
